rps_match_arb: RTL and testbench

RPS_MATCH_ARB -- requirements
Module: rps_match_arb

---
 rtl/rps_match_arb.sv | 187 ++++++++++++++++++
 tb/tb_rps_match_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rps_match_arb.sv
// rtl/rps_match_arb.sv - multi-player rock/paper/scissors round judge and match scorekeeper
module rps_match_arb #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 32,
    parameter int WIN_TARGET  = 3,
    localparam int IDX_W      = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2*NUM_PLAYERS-1:0]       move,
    input  logic [NUM_PLAYERS-1:0]         go,
    output logic                           ack,
    output logic                           busy,
    output logic                           round_valid,
    output logic [NUM_PLAYERS-1:0]         round_win,
    output logic                           bad_move,
    output logic [SCORE_W-1:0]             tie_cnt,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           match_done,
    output logic [IDX_W-1:0]               match_winner
);

    localparam int RW = $clog2(WIN_TARGET + 1);

    // Move encodings
    localparam logic [1:0] MV_NONE     = 2'b00;
    localparam logic [1:0] MV_ROCK     = 2'b01;
    localparam logic [1:0] MV_PAPER    = 2'b10;
    localparam logic [1:0] MV_SCISSORS = 2'b11;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        JUDGE   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                           state, state_n;
    logic [2*NUM_PLAYERS-1:0]         mv_q, mv_n;
    logic [NUM_PLAYERS-1:0][RW-1:0]   rcnt, rcnt_n;

    logic                             ack_n;
    logic                             busy_n;
    logic                             rv_n;
    logic [NUM_PLAYERS-1:0]           rw_n;
    logic                             bad_n;
    logic [SCORE_W-1:0]               tie_n;
    logic [NUM_PLAYERS*SCORE_W-1:0]   score_n;
    logic                             md_n;
    logic [IDX_W-1:0]                 mw_n;

    // Round classification of the captured moves
    logic                             any_none;
    logic                             has_r;
    logic                             has_p;
    logic                             has_s;
    logic [1:0]                       n_distinct;
    logic [1:0]                       win_mv;
    logic                             found;

    // Summarise which moves appear in the captured round and which one beats the other
    always_comb begin
        any_none = 1'b0;
        has_r    = 1'b0;
        has_p    = 1'b0;
        has_s    = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            case (mv_q[2*i +: 2])
                MV_NONE:  any_none = 1'b1;
                MV_ROCK:  has_r    = 1'b1;
                MV_PAPER: has_p    = 1'b1;
                default:  has_s    = 1'b1;
            endcase
        end
        n_distinct = {1'b0, has_r} + {1'b0, has_p} + {1'b0, has_s};
        // Only meaningful when exactly two distinct moves are present
        if (has_r && has_s) begin
            win_mv = MV_ROCK;
        end else if (has_s && has_p) begin
            win_mv = MV_SCISSORS;
        end else begin
            win_mv = MV_PAPER;
        end
    end

    // Next-state and next-output logic for the collect/judge/done sequence
    always_comb begin
        state_n = state;
        mv_n    = mv_q;
        rcnt_n  = rcnt;
        ack_n   = 1'b0;
        rv_n    = 1'b0;
        rw_n    = '0;
        bad_n   = 1'b0;
        tie_n   = tie_cnt;
        score_n = score;
        md_n    = 1'b0;
        mw_n    = match_winner;
        found   = 1'b0;

        case (state)
            COLLECT: begin
                // A round starts only when every player is ready at once
                if (&go) begin
                    mv_n    = move;
                    ack_n   = 1'b1;
                    state_n = JUDGE;
                end
            end

            JUDGE: begin
                rv_n    = 1'b1;
                state_n = COLLECT;
                if (any_none) begin
                    bad_n = 1'b1;
                end else if (n_distinct != 2'd2) begin
                    if (tie_cnt != {SCORE_W{1'b1}}) begin
                        tie_n = tie_cnt + SCORE_W'(1);
                    end
                end else begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (mv_q[2*i +: 2] == win_mv) begin
                            rw_n[i]   = 1'b1;
                            rcnt_n[i] = rcnt[i] + RW'(1);
                            if (rcnt_n[i] == RW'(WIN_TARGET)) begin
                                state_n = DONE;
                            end
                        end
                    end
                end
            end

            DONE: begin
                // Simultaneous finishers: the lowest index takes the match
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (!found && rcnt[i] == RW'(WIN_TARGET)) begin
                        found = 1'b1;
                        mw_n  = IDX_W'(i);
                        if (score[i*SCORE_W +: SCORE_W] != {SCORE_W{1'b1}}) begin
                            score_n[i*SCORE_W +: SCORE_W] = score[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
                        end
                    end
                end
                md_n    = 1'b1;
                rcnt_n  = '0;
                state_n = COLLECT;
            end

            default: begin
                state_n = COLLECT;
            end
        endcase

        busy_n = (state_n != COLLECT);
    end

    // State, counters and all outputs update on the clock; reset abandons any pending result
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= COLLECT;
            mv_q         <= '0;
            rcnt         <= '0;
            ack          <= 1'b0;
            busy         <= 1'b0;
            round_valid  <= 1'b0;
            round_win    <= '0;
            bad_move     <= 1'b0;
            tie_cnt      <= '0;
            score        <= '0;
            match_done   <= 1'b0;
            match_winner <= '0;
        end else begin
            state        <= state_n;
            mv_q         <= mv_n;
            rcnt         <= rcnt_n;
            ack          <= ack_n;
            busy         <= busy_n;
            round_valid  <= rv_n;
            round_win    <= rw_n;
            bad_move     <= bad_n;
            tie_cnt      <= tie_n;
            score        <= score_n;
            match_done   <= md_n;
            match_winner <= mw_n;
        end
    end

endmodule

// File: tb/tb_rps_match_arb.sv
// tb/tb_rps_match_arb.sv - self-checking bench for rps_match_arb against a rules-level model
module tb_rps_match_arb;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam int WT = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [5:0]   move = '0;
    logic [2:0]   go = '0;
    logic         ack;
    logic         busy;
    logic         round_valid;
    logic [2:0]   round_win;
    logic         bad_move;
    logic [1:0]   tie_cnt;
    logic [5:0]   score;
    logic         match_done;
    logic [1:0]   match_winner;

    int checks   = 0;
    int failures = 0;

    // Model state: round wins per player, match scores, ties, last match winner
    int m_wins[3];
    int m_score[3];
    int m_tie;
    int m_winner;

    rps_match_arb #(
        .NUM_PLAYERS(N),
        .SCORE_W(SW),
        .WIN_TARGET(WT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .move(move),
        .go(go),
        .ack(ack),
        .busy(busy),
        .round_valid(round_valid),
        .round_win(round_win),
        .bad_move(bad_move),
        .tie_cnt(tie_cnt),
        .score(score),
        .match_done(match_done),
        .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 1=rock, 2=paper, 3=scissors
    function automatic bit beats(input int x, input int y);
        return (x == 1 && y == 3) || (x == 3 && y == 2) || (x == 2 && y == 1);
    endfunction

    function automatic logic [5:0] exp_score();
        return {2'(m_score[2]), 2'(m_score[1]), 2'(m_score[0])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_wins[i]  = 0;
            m_score[i] = 0;
        end
        m_tie    = 0;
        m_winner = 0;
    endtask

    // Drive one accepted round starting right after a falling edge and check every cycle of it
    task automatic play_round(input int a, input int b, input int c);
        int         m[3];
        bit         bad;
        bit         done;
        int         nd;
        int         wmv;
        int         first;
        logic [2:0] rw;

        m[0] = a; m[1] = b; m[2] = c;
        bad = 1'b0; done = 1'b0; wmv = 0; rw = '0; nd = 0;
        for (int i = 0; i < 3; i++) if (m[i] == 0) bad = 1'b1;
        if (!bad) begin
            for (int v = 1; v <= 3; v++) if (m[0] == v || m[1] == v || m[2] == v) nd++;
            if (nd != 2) begin
                if (m_tie < SMAX) m_tie++;
            end else begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (beats(m[i], m[j])) wmv = m[i];
                for (int i = 0; i < 3; i++) begin
                    if (m[i] == wmv) begin
                        rw[i] = 1'b1;
                        m_wins[i]++;
                    end
                end
                first = -1;
                for (int i = 0; i < 3; i++) if (first < 0 && m_wins[i] >= WT) first = i;
                if (first >= 0) begin
                    done = 1'b1;
                    m_winner = first;
                    if (m_score[first] < SMAX) m_score[first]++;
                    for (int i = 0; i < 3; i++) m_wins[i] = 0;
                end
            end
        end

        go   = 3'b111;
        move = {2'(c), 2'(b), 2'(a)};
        @(negedge clk);
        check("ack", ack, 1);
        check("busy_judge", busy, 1);
        check("rv_early", round_valid, 0);
        // Inputs presented while busy must be ignored
        move = 6'($urandom);
        @(negedge clk);
        go = 3'b000;
        check("round_valid", round_valid, 1);
        check("round_win", round_win, rw);
        check("bad_move", bad_move, bad);
        check("tie_cnt", tie_cnt, m_tie);
        check("ack_pulse", ack, 0);
        check("busy_after_judge", busy, done);
        if (done) begin
            @(negedge clk);
            check("match_done", match_done, 1);
            check("busy_done", busy, 0);
            check("rv_pulse", round_valid, 0);
        end else begin
            check("no_match_done", match_done, 0);
        end
        check("score", score, exp_score());
        check("match_winner", match_winner, m_winner);
    endtask

    function automatic int rand_move();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(1, 3));
    endfunction

    initial begin
        model_reset();

        // Reset held for two cycles
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", round_valid, 0);
        check("rst_rw", round_win, 0);
        check("rst_bad", bad_move, 0);
        check("rst_tie", tie_cnt, 0);
        check("rst_score", score, 0);
        check("rst_md", match_done, 0);
        check("rst_mw", match_winner, 0);
        rst = 1'b1;
        @(negedge clk);

        // Rock vs two scissors: player 0 takes the round
        play_round(1, 3, 3);
        check("rss_win", round_win, 3'b001);
        check("rss_tie", tie_cnt, 0);

        // All three moves present: tie
        play_round(1, 2, 3);
        check("rps_tie", tie_cnt, 1);

        // Partial readiness never starts a round
        for (int k = 0; k < 6; k++) begin
            go   = (k == 0) ? 3'b011 : 3'($urandom_range(0, 6));
            move = 6'($urandom);
            @(negedge clk);
            check("partial_go_ack", ack, 0);
            check("partial_go_busy", busy, 0);
        end
        go = 3'b000;

        // Player 1 wins two rounds and the match
        play_round(3, 1, 3);
        play_round(3, 1, 3);
        check("p1_winner", match_winner, 1);
        check("p1_score", score[3:2], 1);

        // A missing move discards the round
        play_round(0, 1, 2);
        check("bad_tie", tie_cnt, 1);

        // Player 0 wins four matches; its 2-bit score saturates
        repeat (8) play_round(2, 1, 1);
        check("p0_sat", score[1:0], 3);

        // Reset while judging drops the pending round
        go   = 3'b111;
        move = {2'd3, 2'd3, 2'd1};
        @(negedge clk);
        check("rstj_ack", ack, 1);
        rst = 1'b0;
        go  = 3'b000;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("rstj_rv", round_valid, 0);
        check("rstj_busy", busy, 0);
        check("rstj_score", score, 0);
        check("rstj_tie", tie_cnt, 0);
        @(negedge clk);
        check("rstj_rv2", round_valid, 0);
        check("rstj_busy2", busy, 0);

        // Random rounds against the model
        for (int k = 0; k < 60; k++) begin
            play_round(rand_move(), rand_move(), rand_move());
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
